qlm_product_accumulator: RTL
============================

// Module: qlm_product_accumulator
// PURPOSE
//  Downstream stage of the registered QLM multiplier top (16x16 -> 32-bit product).
//  Consumes a stream of unsigned 32-bit products and sums each group of VEC_LEN of them.
//  Each completed sum is presented on a valid/ready output port, with a sticky overflow flag.
//  A one-entry output register decouples the accumulator from the consumer, so the next
//  group accumulates while the previous sum waits.
// PARAMETERS
//  P_W      32  product width (2x multiplier operand width); from shared package
//  ACC_W    40  accumulator/result width; sums wrap modulo 2^ACC_W
//  VEC_LEN  16  products per group; legal range 2..256
//  CNT_W    $clog2(VEC_LEN)  localparam, beat-counter width
// PORTS
//  clk        in   1      single clock; rising-edge
//  rst_n      in   1      asynchronous active-low reset
//  clr        in   1      synchronous abort of the current group and output slot
//  in_valid   in   1      product beat valid
//  in_ready   out  1      stage can accept a beat this cycle
//  in_data    in   P_W    unsigned product; zero-extended to ACC_W
//  out_valid  out  1      out_sum/out_ovf hold a completed group
//  out_ready  in   1      consumer takes the result this cycle
//  out_sum    out  ACC_W  group sum modulo 2^ACC_W
//  out_ovf    out  1      1 = at least one carry out of ACC_W occurred in this group
// BEHAVIOUR
//  - Reset (rst_n=0, async): acc=0, cnt=0, ovf_acc=0, out_valid=0, out_sum=0, out_ovf=0.
//    in_ready is 1 from the first cycle after release.
//  - State = {cnt, out_valid}. "Slot free" = !out_valid || out_ready.
//  - in_ready = !clr && (cnt != VEC_LEN-1 || slot free).
//    Combinational in clr/out_ready; no other combinational paths.
//  - Accept = in_valid && in_ready. Non-final accept (cnt<VEC_LEN-1):
//    acc <= acc+in_data; cnt++; ovf_acc |= carry.
//  - Final accept (cnt==VEC_LEN-1):
//    out_sum <= acc+in_data; out_ovf <= ovf_acc|carry; out_valid <= 1;
//    acc, cnt, ovf_acc <= 0.
//  - Latency: result visible the cycle after the final accept. Back-to-back groups run at
//    full rate, with no bubble.
//  - Output handshake: out_valid && out_ready clears out_valid next cycle, unless a final
//    accept happens in the same cycle. In that case out_valid stays 1 and out_sum/out_ovf
//    load the new group.
//  - While out_valid && !out_ready, out_sum/out_ovf are stable. Non-final beats of the
//    next group are still accepted. The final beat stalls (in_ready=0).
//  - clr=1 (priority over everything except reset): acc, cnt, ovf_acc, out_valid <= 0.
//    Any beat presented that cycle is not accepted (in_ready=0). out_sum/out_ovf keep
//    their value but are invalid.
//  - in_valid with in_ready=0: beat is not consumed; the producer holds it.
//  - Reset mid-group or mid-handshake: partial sum and pending result are discarded.
// STRUCTURE
//  - Shared package qlm_pkg: P_W (=32), operand width (=16), and default ACC_W/VEC_LEN.
//    mult_top and this stage use the same constants.
//  - No sub-module is natural. One sequential process covers acc/cnt/ovf and the output
//    register. ACC_W+1-bit add for the carry. in_ready is a continuous assign.
// TESTING
//  1. rst_n low for 3 cycles mid-group (cnt=5) -> all outputs 0; after release in_ready=1.
//     Next group starts from cnt=0.
//  2. VEC_LEN=4, beats 1,2,3,4 back-to-back, out_ready=1 -> out_sum=10, out_ovf=0.
//     out_valid high exactly 1 cycle, the cycle after beat 4.
//  3. VEC_LEN=4, out_ready=0, 8 beats of 0xFFFF_FFFF -> out_sum=0x3_FFFF_FFFC held.
//     in_ready=0 while cnt==3 of group 2. Raising out_ready gives group 2 = 0x3_FFFF_FFFC
//     the next cycle.
//  4. VEC_LEN=4, continuous stream 1..8 with out_ready=1 -> sums 10 and 26 on consecutive
//     groups. The final accept coincides with the output handshake, with no idle cycle.
//  5. ACC_W=33, VEC_LEN=4, 4 beats of 0xFFFF_FFFF -> out_sum=0x1_FFFF_FFFC, out_ovf=1.
//     The next group of 1,1,1,1 gives out_sum=4 and out_ovf=0.
//  6. clr pulse after 2 beats of group, with a pending unread result -> out_valid=0 and
//     in_ready=0 during clr. Next beats 1,1,1,1 give out_sum=4.
//  - Bench also checks: out_sum/out_ovf stable while out_valid && !out_ready, and no beat
//    is lost or duplicated under random in_valid/out_ready. Scoreboard compares against a
//    reference sum modulo 2^ACC_W.

Source files
------------

// File: rtl/qlm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : qlm_pkg                                                     |
// | Purpose  : Constants shared by the QLM multiplier top and the product  |
// |            accumulator, so both agree on operand/product widths and    |
// |            on the accumulator defaults.                                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package qlm_pkg;

   localparam int OP_W        = 16;        // multiplier operand width
   localparam int P_W         = 2 * OP_W;  // full product width
   localparam int ACC_W_DEF   = 40;        // default accumulator width
   localparam int VEC_LEN_DEF = 16;        // default products per group

endpackage : qlm_pkg
`default_nettype wire

// File: rtl/qlm_product_accumulator_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : qlm_product_accumulator_if                                  |
// | Purpose  : Bundle of the accumulator's product-input stream, the       |
// |            group-result output stream and the synchronous clear.       |
// | Ports    : clr                         - abort current group and slot  |
// |            in_valid/in_ready/in_data   - product beats (to the stage)  |
// |            out_valid/out_ready         - result handshake              |
// |            out_sum/out_ovf             - group sum and overflow flag   |
// |            master = producer/consumer side, slave = accumulator side.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface qlm_product_accumulator_if #(
   parameter int DATA_W = qlm_pkg::P_W,
   parameter int SUM_W  = qlm_pkg::ACC_W_DEF
);

   logic              clr;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [SUM_W-1:0]  out_sum;
   logic              out_ovf;

   modport master (
      output clr, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  clr, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );

endinterface : qlm_product_accumulator_if
`default_nettype wire

// File: rtl/qlm_product_accumulator.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : qlm_product_accumulator                                     |
// | Purpose  : Sums each group of VEC_LEN unsigned products into an ACC_W  |
// |            wide result (wrapping) with a sticky carry-out flag, and    |
// |            presents it through a one-entry output register so the     |
// |            next group accumulates while the previous result waits.     |
// | Ports    : clk   - rising-edge clock                                   |
// |            rst_n - asynchronous active-low reset                       |
// |            bus   - slave side of qlm_product_accumulator_if            |
// |                    (clr, in_* product stream, out_* result stream)     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module qlm_product_accumulator
   import qlm_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,   // must be >= P_W
   parameter int VEC_LEN = VEC_LEN_DEF  // 2..256
) (
   input  logic                            clk,
   input  logic                            rst_n,
   qlm_product_accumulator_if.slave        bus
);

   localparam int               CNT_W     = $clog2(VEC_LEN);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf_acc;
   logic             out_valid;
   logic [ACC_W-1:0] out_sum;
   logic             out_ovf;

   logic             last_beat;
   logic             slot_free;
   logic             accept;
   logic [ACC_W:0]   sum_ext;   // MSB is the carry out of this beat's add

   assign last_beat = (cnt == LAST_BEAT);
   // The output slot can take a new result if empty or being drained now.
   assign slot_free = !out_valid || bus.out_ready;
   // Only the final beat of a group needs the slot; earlier beats never stall.
   assign bus.in_ready = !bus.clr && (!last_beat || slot_free);
   assign accept       = bus.in_valid && bus.in_ready;

   assign sum_ext = {1'b0, acc} + {{(ACC_W + 1 - P_W){1'b0}}, bus.in_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         cnt       <= '0;
         ovf_acc   <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
      end else if (bus.clr) begin
         // out_sum/out_ovf deliberately keep their stale contents.
         acc       <= '0;
         cnt       <= '0;
         ovf_acc   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && bus.out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (last_beat) begin
               // Overrides the drain above when both happen together.
               out_sum   <= sum_ext[ACC_W-1:0];
               out_ovf   <= ovf_acc | sum_ext[ACC_W];
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
               ovf_acc   <= 1'b0;
            end else begin
               acc       <= sum_ext[ACC_W-1:0];
               cnt       <= cnt + CNT_W'(1);
               ovf_acc   <= ovf_acc | sum_ext[ACC_W];
            end
         end
      end
   end

   assign bus.out_valid = out_valid;
   assign bus.out_sum   = out_sum;
   assign bus.out_ovf   = out_ovf;

endmodule : qlm_product_accumulator
`default_nettype wire
